axi4_mmio_timer: RTL
====================

Name: axi4_mmio_timer

Overview:
- AXI4 slave peripheral on the Rocket MMIO port. Takes the place of the scratch SRAM currently attached there.
- Provides a prescaled 64-bit free-running counter and two compare channels.
- Drives the core's 2-bit `interrupts` input, closing the loop from MMIO writes back to core interrupts.

Parameters:
- AXI_ADDRESS_WIDTH, 32, width of AWADDR/ARADDR; only ADDR[7:0] decoded.
- AXI_DATA_WIDTH, 64, data bus width; only 64 is supported.
- AXI_ID_WIDTH, 4, width of AWID/ARID/BID/RID.
- PRESCALE_RESET, 0, reset value of PRESCALE register.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- s  axi4_if.slave  param  AXI4 slave port; widths set by the AXI_* parameters.
- irq  out  2  level interrupts; bit i = STATUS[i] & CTRL.IE[i].

Behaviour:
- Register map, 8-byte aligned, decoded from ADDR[7:3]:
  - 0x00 CTRL: [0] EN, [1] IE0, [2] IE1.
  - 0x08 PRESCALE: [15:0].
  - 0x10 COUNT: [63:0].
  - 0x18 CMP0: [63:0].
  - 0x20 CMP1: [63:0].
  - 0x28 STATUS: [1:0], write-1-to-clear.
  - Unused register bits read 0.
- Unmapped offsets (0x30 and above): reads return 0 with RRESP=2'b10; writes are dropped with BRESP=2'b10.
- Mapped accesses respond OKAY (2'b00).
- Reset values:
  - CTRL=0, PRESCALE=PRESCALE_RESET, COUNT=0, CMP0=CMP1=all-ones, STATUS=0.
  - Prescale counter=0, irq=0.
  - AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0.
- Prescaler:
  - When EN=1, an internal 16-bit counter counts 0..PRESCALE.
  - A tick occurs when it equals PRESCALE; it then returns to 0.
  - COUNT increments by 1 on each tick, i.e. every PRESCALE+1 cycles, wrapping 2^64-1 to 0.
  - EN=0 freezes both counters.
- Compare: STATUS[i] sets on the cycle after COUNT==CMPi while EN=1. It is sticky; IE only masks irq.
- Write FSM (W_IDLE -> W_DATA -> W_RESP):
  - W_IDLE: AWREADY=1. On AW handshake, latch AWID, AWADDR and AWLEN, then go to W_DATA.
  - W_DATA: WREADY=1. Each beat writes the bytes enabled by WSTRB at the current address; address += 8 per beat (INCR only; other burst types are treated as INCR).
  - On the beat with WLAST, or after AWLEN+1 beats, go to W_RESP.
  - W_RESP: BVALID=1 with latched BID. BRESP is SLVERR if any beat was unmapped. Hold until BREADY, then return to W_IDLE.
- Read FSM (R_IDLE -> R_DATA):
  - R_IDLE: ARREADY=1. On AR handshake, latch ARID, ARADDR and ARLEN.
  - R_DATA: RVALID=1 with registered RDATA/RRESP and RLAST on beat ARLEN. Data and address advance only on RVALID&RREADY; data is stable while stalled.
  - After the last beat, return to R_IDLE.
- Read and write FSMs are independent; one outstanding transaction each.
- Minimum latency: AW handshake to BVALID is 2 cycles for a single beat. AR handshake to RVALID is 1 cycle.
- Precedence, same cycle:
  - A bus write to COUNT beats a tick increment and also zeroes the prescale counter.
  - For STATUS, a compare set beats a W1C clear.
  - A write to CMPi takes effect for the compare on the next cycle.
- Reads of COUNT return the value registered at the read beat (single 64-bit access, no tearing).
- rst asserted mid-transaction: FSMs abort to idle and all registers return to reset values. No B or R response is issued for the aborted transaction.

Optional Feature:
- Macro: AXI4_MMIO_TIMER_ONESHOT_EN.
- Defined: CTRL[3]=ONESHOT is implemented. When ONESHOT=1 and STATUS[0] sets, EN clears on the same edge, so COUNT stops at CMP0+1 or earlier.
- Not defined: CTRL[3] reads 0, writes are ignored, and the timer is always free-running.

Test Plan:
- Reset then read all six registers: CTRL=0, PRESCALE=0, COUNT=0, CMP0=CMP1=0xFFFF_FFFF_FFFF_FFFF, STATUS=0, every RRESP=0.
- Write PRESCALE=3, CMP0=5, CTRL=0x3, with irq polled:
  - COUNT increments every 4 cycles.
  - irq[0] rises 1 cycle after COUNT==5 (about 21 cycles after EN).
  - Writing STATUS=0x1 drops irq[0] the next cycle.
- 4-beat INCR write at 0x10 (COUNT, CMP0, CMP1, STATUS) with WSTRB=0x0F on beat 1:
  - Only COUNT[31:0] changes.
  - Single B response with matching BID.
  - A 4-beat read back returns matching data with RLAST on beat 4 only.
- Read 0x30, and write 0x38 with AWLEN=0: RDATA=0, RRESP=2'b10; BRESP=2'b10; no register changes.
- Back-pressure and reset:
  - Hold RREADY=0 for 10 cycles during a 2-beat read: RDATA/RLAST stay stable.
  - Assert rst mid-W_DATA: BVALID never asserts and AWREADY=1 in the first cycle after rst deasserts.
- With AXI4_MMIO_TIMER_ONESHOT_EN defined, CMP0=2, CTRL=0x9: COUNT stops at 3, CTRL reads 0x8, STATUS=1.

Source files
------------

// File: rtl/axi4_mmio_timer_if.sv
// AXI4 bus bundle for the MMIO timer; the peripheral connects through the slave modport.
interface axi4_if #(
    parameter int unsigned AXI_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH    = 64,
    parameter int unsigned AXI_ID_WIDTH      = 4
);
    logic [AXI_ID_WIDTH-1:0]       awid;
    logic [AXI_ADDRESS_WIDTH-1:0]  awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awvalid;
    logic                          awready;
    logic [AXI_DATA_WIDTH-1:0]     wdata;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;
    logic [AXI_ID_WIDTH-1:0]       bid;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [AXI_ID_WIDTH-1:0]       arid;
    logic [AXI_ADDRESS_WIDTH-1:0]  araddr;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arvalid;
    logic                          arready;
    logic [AXI_ID_WIDTH-1:0]       rid;
    logic [AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_mmio_timer.sv
// AXI4 MMIO timer: prescaled 64-bit counter, two sticky compare channels, level irq.
// Optional CTRL[3] ONESHOT support is enabled by defining AXI4_MMIO_TIMER_ONESHOT_EN.
module axi4_mmio_timer #(
    parameter int unsigned AXI_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH    = 64,
    parameter int unsigned AXI_ID_WIDTH      = 4,
    parameter logic [15:0] PRESCALE_RESET    = 16'd0
) (
    input  logic       clk,
    input  logic       rst,
    axi4_if.slave      s,
    output logic [1:0] irq
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    localparam logic [4:0] A_CTRL     = 5'd0;
    localparam logic [4:0] A_PRESCALE = 5'd1;
    localparam logic [4:0] A_COUNT    = 5'd2;
    localparam logic [4:0] A_CMP0     = 5'd3;
    localparam logic [4:0] A_CMP1     = 5'd4;
    localparam logic [4:0] A_STATUS   = 5'd5;

`ifdef AXI4_MMIO_TIMER_ONESHOT_EN
    localparam int unsigned CTRL_W = 4;
`else
    localparam int unsigned CTRL_W = 3;
`endif

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic [AXI_ID_WIDTH-1:0]   r_wid, r_rid;
    logic [4:0]                r_waddr, r_raddr;
    logic [7:0]                r_wlen, r_wbeat, r_rlen, r_rbeat;
    logic                      r_werr;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;

    logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;
    logic [15:0]       r_prescale, r_pscnt;
    logic [63:0]       r_count, r_cmp0, r_cmp1;
    logic [1:0]        r_status;

    logic                      w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic                      w_en, w_tick;
    logic [1:0]                w_match, w_clr;
    logic [63:0]               w_bmask, w_wcur, w_wnew;
    logic [4:0]                w_rd_idx;
    logic [AXI_DATA_WIDTH-1:0] w_rd_data;
    logic                      w_rd_err;
    logic                      w_unused;

    assign w_unused = ^{s.awaddr[AXI_ADDRESS_WIDTH-1:8], s.awaddr[2:0], s.awsize, s.awburst,
                        s.araddr[AXI_ADDRESS_WIDTH-1:8], s.araddr[2:0], s.arsize, s.arburst};

    function automatic logic [63:0] f_regval(input logic [4:0] idx);
        logic [63:0] v;
        v = '0;
        case (idx)
            A_CTRL:     v = {{(64-CTRL_W){1'b0}}, r_ctrl};
            A_PRESCALE: v = {48'd0, r_prescale};
            A_COUNT:    v = r_count;
            A_CMP0:     v = r_cmp0;
            A_CMP1:     v = r_cmp1;
            A_STATUS:   v = {62'd0, r_status};
            default:    v = '0;
        endcase
        return v;
    endfunction

    // ---------------- write channel FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        s.awready    = 1'b0;
        s.wready     = 1'b0;
        s.bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s.awready = 1'b1;
                if (s.awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s.wready = 1'b1;
                if (s.wvalid && (s.wlast || r_wbeat == r_wlen)) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s.bvalid = 1'b1;
                if (s.bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        if (rst) begin
            s.awready = 1'b0;
            s.wready  = 1'b0;
            s.bvalid  = 1'b0;
        end
    end

    assign w_aw_hs = s.awvalid && s.awready;
    assign w_w_hs  = s.wvalid && s.wready;
    assign s.bid   = r_wid;
    assign s.bresp = r_werr ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wid   <= '0;
            r_waddr <= '0;
            r_wlen  <= '0;
            r_wbeat <= '0;
            r_werr  <= 1'b0;
        end else if (w_aw_hs) begin
            r_wid   <= s.awid;
            r_waddr <= s.awaddr[7:3];
            r_wlen  <= s.awlen;
            r_wbeat <= '0;
            r_werr  <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= r_waddr + 5'd1;
            r_wbeat <= r_wbeat + 8'd1;
            r_werr  <= r_werr | (r_waddr > A_STATUS);
        end
    end

    // Byte-lane merge of the beat into whichever register the beat addresses.
    always_comb begin
        w_bmask = '0;
        for (int unsigned i = 0; i < 8; i++) w_bmask[8*i +: 8] = {8{s.wstrb[i]}};
    end

    assign w_wcur = f_regval(r_waddr);
    assign w_wnew = (w_wcur & ~w_bmask) | (s.wdata & w_bmask);
    assign w_clr  = (w_w_hs && r_waddr == A_STATUS) ? (s.wdata[1:0] & w_bmask[1:0]) : 2'b00;

    // ---------------- timer core ----------------
    assign w_en       = r_ctrl[0];
    assign w_tick     = w_en && (r_pscnt == r_prescale);
    assign w_match[0] = w_en && (r_count == r_cmp0);
    assign w_match[1] = w_en && (r_count == r_cmp1);

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_w_hs && r_waddr == A_CTRL) w_ctrl_nxt = w_wnew[CTRL_W-1:0];
`ifdef AXI4_MMIO_TIMER_ONESHOT_EN
        if (r_ctrl[3] && w_match[0]) w_ctrl_nxt[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_prescale <= PRESCALE_RESET;
            r_pscnt    <= '0;
            r_count    <= '0;
            r_cmp0     <= '1;
            r_cmp1     <= '1;
            r_status   <= '0;
        end else begin
            r_ctrl <= w_ctrl_nxt;
            if (w_w_hs && r_waddr == A_PRESCALE) r_prescale <= w_wnew[15:0];
            // A bus write to COUNT overrides the tick and restarts the prescale phase.
            if (w_w_hs && r_waddr == A_COUNT) begin
                r_count <= w_wnew;
                r_pscnt <= '0;
            end else if (w_tick) begin
                r_count <= r_count + 64'd1;
                r_pscnt <= '0;
            end else if (w_en) begin
                r_pscnt <= r_pscnt + 16'd1;
            end
            if (w_w_hs && r_waddr == A_CMP0) r_cmp0 <= w_wnew;
            if (w_w_hs && r_waddr == A_CMP1) r_cmp1 <= w_wnew;
            r_status <= (r_status & ~w_clr) | w_match;
        end
    end

    assign irq = r_status & r_ctrl[2:1];

    // ---------------- read channel FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        s.arready    = 1'b0;
        s.rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s.arready = 1'b1;
                if (s.arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                s.rvalid = 1'b1;
                if (s.rready && s.rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        if (rst) begin
            s.arready = 1'b0;
            s.rvalid  = 1'b0;
        end
    end

    assign w_ar_hs  = s.arvalid && s.arready;
    assign w_r_hs   = s.rvalid && s.rready;
    assign s.rid    = r_rid;
    assign s.rdata  = r_rdata;
    assign s.rresp  = r_rresp;
    assign s.rlast  = (r_rstate == R_DATA) && (r_rbeat == r_rlen);

    // Next beat's data is fetched when the current one is accepted, so RDATA holds while stalled.
    assign w_rd_idx  = (r_rstate == R_IDLE) ? s.araddr[7:3] : r_raddr + 5'd1;
    assign w_rd_data = f_regval(w_rd_idx);
    assign w_rd_err  = w_rd_idx > A_STATUS;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rid   <= '0;
            r_raddr <= '0;
            r_rlen  <= '0;
            r_rbeat <= '0;
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (w_ar_hs) begin
            r_rid   <= s.arid;
            r_raddr <= s.araddr[7:3];
            r_rlen  <= s.arlen;
            r_rbeat <= '0;
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_err ? 2'b10 : 2'b00;
        end else if (w_r_hs && !s.rlast) begin
            r_raddr <= r_raddr + 5'd1;
            r_rbeat <= r_rbeat + 8'd1;
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_err ? 2'b10 : 2'b00;
        end
    end
endmodule
